// File: rtl/lcd_pixel_stream_aligner.sv
// Buffers an RGB666 valid/ready pixel stream and locks it to panel HSync/VSync/DE timing.
// Define LCD_ALIGN_ERR_COUNT_EN to add the saturating err_cnt output.
module lcd_pixel_stream_aligner #(
  parameter int          DEPTH      = 16,
  parameter int          AW         = 4,
  parameter logic [17:0] FILL_COLOR = 18'h00000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [17:0]   s_data,
  input  logic          s_sof,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          de_in,
  input  logic          err_clr,
  output logic [20:0]   video_data,
  output logic          locked,
  output logic          underflow,
  output logic          sync_err,
  output logic [AW:0]   fifo_level
`ifdef LCD_ALIGN_ERR_COUNT_EN
  ,
  output logic [7:0]    err_cnt
`endif
);

  typedef enum logic [1:0] {SEEK, ARMED, WAIT_DE, STREAM} state_t;

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  state_t        state, state_n;
  logic [18:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   level;
  logic          frame_start, frame_start_n;
  logic          vsync_prev;
  logic          accept, wr_en, rd_en, flush;
  logic          set_uf, set_se;
  logic [17:0]   rgb_n;
  logic [18:0]   head;
  logic          fifo_empty;

  assign head       = mem[rptr];
  assign fifo_empty = (level == '0);
  assign s_ready    = (state == SEEK) || (level < FULL_LVL);
  assign accept     = s_valid && s_ready;
  assign fifo_level = level;

  always_comb begin
    state_n       = state;
    frame_start_n = frame_start;
    wr_en         = 1'b0;
    rd_en         = 1'b0;
    flush         = 1'b0;
    set_uf        = 1'b0;
    set_se        = 1'b0;
    rgb_n         = FILL_COLOR;
    if (state == STREAM && vsync_in && !vsync_prev)
      frame_start_n = 1'b1;
    unique case (state)
      SEEK: begin
        // Non-SOF words are accepted and dropped until a frame start shows up.
        if (accept && s_sof) begin
          wr_en   = 1'b1;
          state_n = ARMED;
        end
      end
      ARMED: begin
        wr_en = accept;
        if (vsync_in) state_n = WAIT_DE;
      end
      WAIT_DE: begin
        wr_en = accept;
        if (de_in) begin
          rd_en         = 1'b1;
          rgb_n         = head[17:0];
          state_n       = STREAM;
          frame_start_n = 1'b0;
        end
      end
      STREAM: begin
        wr_en = accept;
        if (de_in) begin
          if (fifo_empty) begin
            set_uf  = 1'b1;
            flush   = 1'b1;
            state_n = SEEK;
          end else if (frame_start && !head[18]) begin
            set_se  = 1'b1;
            flush   = 1'b1;
            state_n = SEEK;
          end else if (frame_start) begin
            rd_en         = 1'b1;
            rgb_n         = head[17:0];
            frame_start_n = 1'b0;
          end else if (!head[18]) begin
            rd_en = 1'b1;
            rgb_n = head[17:0];
          end
          // Head is SOF mid-frame: the source frame ran short, pad until next frame.
        end
      end
      default: state_n = SEEK;
    endcase
    if (flush) begin
      wr_en         = 1'b0;
      frame_start_n = 1'b0;
    end
    if (!de_in) rgb_n = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEEK;
      wptr        <= '0;
      rptr        <= '0;
      level       <= '0;
      frame_start <= 1'b0;
      vsync_prev  <= 1'b0;
      video_data  <= '0;
      locked      <= 1'b0;
      underflow   <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_n;
      frame_start <= frame_start_n;
      vsync_prev  <= vsync_in;
      video_data  <= {hsync_in, vsync_in, de_in, rgb_n};
      locked      <= (state_n == STREAM);
      underflow   <= set_uf | (underflow & ~err_clr);
      sync_err    <= set_se | (sync_err & ~err_clr);
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        level <= '0;
      end else begin
        if (wr_en) wptr <= wptr + AW'(1);
        if (rd_en) rptr <= rptr + AW'(1);
        unique case ({wr_en, rd_en})
          2'b10:   level <= level + (AW+1)'(1);
          2'b01:   level <= level - (AW+1)'(1);
          default: level <= level;
        endcase
      end
    end
  end

  // FIFO storage carries only data, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= {s_sof, s_data};
  end

`ifdef LCD_ALIGN_ERR_COUNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt <= '0;
    else if (set_uf || set_se)
      err_cnt <= err_clr ? 8'd1 : sat_inc8(err_cnt);
    else if (err_clr)
      err_cnt <= '0;
  end
`endif

endmodule

// File: tb/tb_lcd_pixel_stream_aligner.sv
// Directed bench for lcd_pixel_stream_aligner on an 8x4 active raster (12x6 total).
module tb_lcd_pixel_stream_aligner;

  localparam logic [17:0] FILL = 18'h2AAAA;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] s_data;
  logic        s_sof, s_valid, s_ready;
  logic        hsync_in, vsync_in, de_in, err_clr;
  logic [20:0] video_data;
  logic        locked, underflow, sync_err;
  logic [4:0]  fifo_level;
`ifdef LCD_ALIGN_ERR_COUNT_EN
  logic [7:0]  err_cnt;
`endif

  always #5 clk = ~clk;

  lcd_pixel_stream_aligner #(.DEPTH(16), .AW(4), .FILL_COLOR(FILL)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_sof(s_sof), .s_valid(s_valid),
    .s_ready(s_ready), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
    .err_clr(err_clr), .video_data(video_data), .locked(locked),
    .underflow(underflow), .sync_err(sync_err), .fifo_level(fifo_level)
`ifdef LCD_ALIGN_ERR_COUNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  typedef struct {
    logic        hs, vs, de, vld, sof;
    logic [17:0] d;
    logic [20:0] exp_vd;
    logic        exp_rdy;
    logic [4:0]  exp_lvl;
  } vec_t;

  vec_t        tbl [8];
  int          checks = 0;
  int          errors = 0;
  int          row, col;
  logic [18:0] src_q [$];
  logic [17:0] de_rgb [32];
  logic        de_lock [32];
  logic        de_uf [32];
  logic        de_se [32];
  logic [4:0]  de_lvl [32];
  logic        de_rdy [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int base, input int n, input bit sof_first);
    for (int k = 0; k < n; k++)
      src_q.push_back({(sof_first && k == 0), 18'(base + k)});
  endtask

  // One pixel clock: timing generator plus source, output sampled 1 ns after the edge.
  task automatic cyc();
    logic acc;
    logic [2:0] sync_drv;
    @(negedge clk);
    hsync_in = (col == 9 || col == 10);
    vsync_in = (row == 4);
    de_in    = (row < 4 && col < 8);
    s_valid  = (src_q.size() > 0);
    {s_sof, s_data} = s_valid ? src_q[0] : 19'h0;
    sync_drv = {hsync_in, vsync_in, de_in};
    #1;
    acc = s_valid && s_ready;
    @(posedge clk);
    if (acc) src_q.delete(0);
    #1;
    chk("sync_passthrough", video_data[20:18], sync_drv);
    col++;
    if (col == 12) begin
      col = 0;
      row = (row == 5) ? 0 : row + 1;
    end
  endtask

  // Finish any partial frame, then run one full aligned frame recording each DE output.
  task automatic run_frame();
    int n;
    bit de_now;
    while (!(row == 0 && col == 0)) cyc();
    n = 0;
    for (int c = 0; c < 72; c++) begin
      de_now = (row < 4 && col < 8);
      cyc();
      if (de_now) begin
        de_rgb[n]  = video_data[17:0];
        de_lock[n] = locked;
        de_uf[n]   = underflow;
        de_se[n]   = sync_err;
        de_lvl[n]  = fifo_level;
        de_rdy[n]  = s_ready;
        n++;
      end
    end
  endtask

  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    hsync_in = v.hs; vsync_in = v.vs; de_in = v.de;
    s_valid = v.vld; s_sof = v.sof; s_data = v.d;
    @(posedge clk);
    #1;
    chk("vec_video_data", video_data, v.exp_vd);
    chk("vec_s_ready", s_ready, v.exp_rdy);
    chk("vec_fifo_level", fifo_level, v.exp_lvl);
  endtask

  task automatic idle_inputs();
    hsync_in = 0; vsync_in = 0; de_in = 0; s_valid = 0; s_sof = 0; s_data = '0; err_clr = 0;
  endtask

  initial begin
    int found;
    logic [31:0] e;
    tbl[0] = '{0, 0, 0, 0, 0, 18'h0, 21'h000000, 1'b1, 5'd0};
    tbl[1] = '{1, 0, 0, 0, 0, 18'h0, 21'h100000, 1'b1, 5'd0};
    tbl[2] = '{0, 1, 0, 0, 0, 18'h0, 21'h080000, 1'b1, 5'd0};
    tbl[3] = '{0, 0, 1, 0, 0, 18'h0, 21'h06AAAA, 1'b1, 5'd0};
    tbl[4] = '{0, 0, 1, 1, 0, 18'h5, 21'h06AAAA, 1'b1, 5'd0};
    tbl[5] = '{1, 1, 1, 1, 0, 18'h6, 21'h1EAAAA, 1'b1, 5'd0};
    tbl[6] = '{0, 0, 0, 1, 1, 18'h7, 21'h000000, 1'b1, 5'd1};
    tbl[7] = '{0, 0, 1, 1, 0, 18'h8, 21'h06AAAA, 1'b1, 5'd2};

    idle_inputs();
    rst = 1'b1;
    row = 0; col = 0;
    #12;
    chk("rst_video_data", video_data, 21'h0);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_locked", locked, 1'b0);
    chk("rst_underflow", underflow, 1'b0);
    chk("rst_sync_err", sync_err, 1'b0);
    chk("rst_fifo_level", fifo_level, 5'd0);
    @(negedge clk) rst = 1'b0;

    // SEEK passthrough, fill colour, non-SOF drop, SOF capture into ARMED
    for (int i = 0; i < 8; i++) apply_vec(tbl[i]);

    // Asynchronous reset with non-zero output and level
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_video_data", video_data, 21'h0);
    chk("async_rst_fifo_level", fifo_level, 5'd0);
    idle_inputs();
    @(negedge clk) rst = 1'b0;
    row = 0; col = 0;

    // Lock: three stray words, then frames F0..F4 (F2 short, F4 truncated)
    for (int i = 0; i < 3; i++) src_q.push_back({1'b0, 18'(100 + i)});
    push_frame(0, 32, 1);
    push_frame(64, 32, 1);
    push_frame(128, 30, 1);
    push_frame(192, 32, 1);
    push_frame(256, 21, 1);

    run_frame();
    chk("armed_fill", de_rgb[0], FILL);
    chk("armed_not_locked", de_lock[31], 1'b0);
    chk("bp_full_level", fifo_level, 5'd16);
    chk("bp_full_ready", s_ready, 1'b0);
    chk("pre_lock", locked, 1'b0);

    run_frame();
    chk("lock_rise", de_lock[0], 1'b1);
    chk("bp_pop_level", de_lvl[0], 5'd15);
    chk("bp_pop_ready", de_rdy[0], 1'b1);
    for (int k = 0; k < 32; k++) chk("lock_frame_px", de_rgb[k], k);

    run_frame();
    for (int k = 0; k < 32; k++) chk("frame2_px", de_rgb[k], 64 + k);

    run_frame();
    for (int k = 0; k < 32; k++) begin
      e = (k < 30) ? 32'(128 + k) : 32'(FILL);
      chk("short_frame_px", de_rgb[k], e);
    end
    chk("short_locked", de_lock[31], 1'b1);

    run_frame();
    chk("after_short_locked", de_lock[0], 1'b1);
    chk("no_underflow_yet", de_uf[31], 1'b0);
    for (int k = 0; k < 32; k++) chk("after_short_px", de_rgb[k], 192 + k);

    run_frame();
    for (int k = 0; k < 21; k++) chk("uf_frame_px", de_rgb[k], 256 + k);
    chk("uf_fill", de_rgb[21], FILL);
    chk("uf_flag", de_uf[21], 1'b1);
    chk("uf_level", de_lvl[21], 5'd0);
    chk("uf_unlocked", de_lock[21], 1'b0);
    chk("uf_pre_flag", de_uf[20], 1'b0);
`ifdef LCD_ALIGN_ERR_COUNT_EN
    chk("err_cnt_uf", err_cnt, 8'd1);
`endif
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("uf_cleared", underflow, 1'b0);
`ifdef LCD_ALIGN_ERR_COUNT_EN
    chk("err_cnt_cleared", err_cnt, 8'd0);
`endif

    // Misalignment: F6 loses its SOF flag
    push_frame(320, 32, 1);
    push_frame(384, 32, 0);
    push_frame(448, 32, 1);
    push_frame(512, 32, 1);
    run_frame();
    chk("relock_f5", de_lock[0], 1'b1);
    for (int k = 0; k < 32; k++) chk("f5_px", de_rgb[k], 320 + k);
    run_frame();
    chk("se_fill", de_rgb[0], FILL);
    chk("se_flag", de_se[0], 1'b1);
    chk("se_unlocked", de_lock[0], 1'b0);
    chk("se_level", de_lvl[0], 5'd0);
    chk("se_no_uf", de_uf[0], 1'b0);
`ifdef LCD_ALIGN_ERR_COUNT_EN
    chk("err_cnt_se", err_cnt, 8'd1);
`endif
    found = 0;
    for (int f = 0; f < 3 && found == 0; f++) begin
      run_frame();
      if (de_lock[0]) begin
        found = 1;
        for (int k = 0; k < 32; k++) chk("relock_px", de_rgb[k], 448 + k);
      end
    end
    chk("relock_found", found, 1);

    // Reset in the middle of a locked frame
    repeat (5) cyc();
    chk("pre_reset_locked", locked, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_video_data", video_data, 21'h0);
    chk("mid_rst_s_ready", s_ready, 1'b1);
    chk("mid_rst_locked", locked, 1'b0);
    chk("mid_rst_fifo_level", fifo_level, 5'd0);
    chk("mid_rst_sync_err", sync_err, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_held_video_data", video_data, 21'h0);
    idle_inputs();
    src_q.delete();
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rst_release_video_data", video_data, 21'h0);
    row = 0; col = 0;

`ifdef LCD_ALIGN_ERR_COUNT_EN
    // One forced underflow per two frames: lock on a single SOF word, then starve.
    for (int i = 0; i < 300; i++) begin
      src_q.push_back({1'b1, 18'h0});
      run_frame();
      run_frame();
    end
    chk("err_cnt_saturated", err_cnt, 8'd255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
